prism_sp_acp_copy_seq: RTL and testbench
========================================

# prism_sp_acp_copy_seq

Block-copy sequencer in front of the ACP RAM/AXI transfer engine. Accepts one copy request (direction, ACP RAM byte address, 40-bit AXI byte address, byte length), splits it into 64-byte (4-beat) and 16-byte (1-beat) engine transactions, issues each as a one-cycle start pulse and waits for engine completion. Sits between the SP ACP unit (or any other requester) and the engine's command port, so software issues one request instead of polling per 16/64-byte transfer.

## Interface
- ACPRAM_ADDR_WIDTH, 20: engine ACP RAM address width, in 16-byte units.
- LEN_WIDTH, 16: request length width, in bytes.
- clk  in  1  clock; reset rst, synchronous, active-high.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_dir  in  1  0 = AXI→ACP RAM (engine read), 1 = ACP RAM→AXI (engine write).
- req_acpram_addr  in  ACPRAM_ADDR_WIDTH+4  ACP RAM byte address.
- req_axi_addr  in  40  AXI byte address.
- req_len  in  LEN_WIDTH  byte count.
- abort  in  1  stop at next chunk boundary.
- eng_read, eng_write  out  1 each  one-cycle start pulses.
- eng_acpram_addr  out  ACPRAM_ADDR_WIDTH  chunk RAM address, 16-byte units.
- eng_axi_addr  out  40  chunk AXI byte address.
- eng_len  out  1  1 = 64-byte chunk, 0 = 16-byte chunk.
- eng_busy  in  1  engine busy.
- busy  out  1  request in progress (not IDLE).
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: request rejected.
- aborted  out  1  valid with done: stopped by abort.
- chunks_done  out  LEN_WIDTH-4  chunks completed for current/last request.

## Operation
- States: IDLE, CHECK, ISSUE, SETTLE, WAIT, FIN.
- IDLE: req_valid & req_ready latches all request fields, clears chunks_done → CHECK.
- CHECK: reject (err=1, no engine pulse) if req_len == 0, req_len[3:0] ≠ 0, either address [3:0] ≠ 0, or req_acpram_addr + req_len > 2^(ACPRAM_ADDR_WIDTH+4) (computed one bit wider, no wrap). Reject → FIN; else → ISSUE.
- Chunk size: 64 B if remaining ≥ 64 and both current addresses [5:0] == 0; otherwise 16 B. Misaligned heads therefore run as 16-byte chunks until 64-byte alignment; tails under 64 B run as 16-byte chunks.
- ISSUE: drive eng_acpram_addr = cur_ram[ACPRAM_ADDR_WIDTH+3:4], eng_axi_addr = cur_axi, eng_len; pulse eng_read (dir 0) or eng_write (dir 1) for exactly one cycle → SETTLE.
- SETTLE: one cycle, eng_busy ignored (engine raises busy the cycle after the pulse) → WAIT.
- WAIT: on eng_busy == 0: advance cur_ram, cur_axi, decrement remaining by chunk size, chunks_done++. If remaining == 0 → FIN (aborted=0); else if abort sampled high any cycle since ISSUE → FIN (aborted=1); else → ISSUE.
- FIN: done pulse with err/aborted → IDLE.
- abort in IDLE/CHECK/FIN is ignored; in flight it never truncates an engine transaction.
- Write strobes are not managed here; engine uses its configured strobe registers.
- cur_axi adds at full 40-bit width; wrap past 2^40 is not checked.

## Timing
- Reset: state IDLE, req_ready=1, busy=0, eng_read=eng_write=0, done=err=aborted=0, chunks_done=0, eng addresses/eng_len=0.
- Accept → first engine pulse: 2 cycles (accept edge, CHECK, pulse in ISSUE).
- Per chunk: ISSUE + SETTLE + (engine busy cycles) ≥ 3 cycles; next pulse 1 cycle after WAIT sees busy low.
- Rejected request: done 2 cycles after accept.
- eng_* address/len outputs held stable from ISSUE through WAIT.
- err and aborted are qualified only by done; they hold until next accept.
- Reset mid-request returns to IDLE immediately; engine's in-flight transfer is not tracked.

## Structure
- Shared package (prism_sp_config): state enum typedef, CHUNK_BYTES_64=64, CHUNK_BYTES_16=16.
- One sub-module natural: prism_sp_acp_chunk_sel (combinational: remaining + addresses → eng_len and byte increment).

## Test plan
- ram 0x000, axi 0x1000, len 256, dir 0 → 4 eng_read pulses, eng_len=1, axi 0x1000/1040/1080/10C0, ram 0/4/8/C, chunks_done=4, done err=0.
- ram 0x010, axi 0x2010, len 96 → chunks 16,16,16 (to 0x40), then 16,16,16 since remaining <64 after alignment? Check: 16×3 → 48 left, 16×3; 6 pulses, all eng_len=0.
- ram 0x000, axi 0x3000, len 80, dir 1 → one 64 B eng_write, one 16 B eng_write, done.
- len 0x18 (not 16-multiple) or axi 0x1004 → no pulse, done+err=1 two cycles after accept.
- len 512, abort pulse during 2nd chunk's WAIT → exactly 2 chunks issued, done aborted=1, chunks_done=2.
- engine holding busy 20 cycles per chunk, rst asserted mid-WAIT → next cycle busy=0, req_ready=1, no further pulses.

Source files
------------

// File: rtl/prism_sp_acp_copy_seq_pkg.sv
// Shared definitions for the SP ACP block-copy sequencer: FSM state encoding
// and engine chunk sizes.
package prism_sp_config;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_FIN
  } state_t;

  localparam int CHUNK_BYTES_64 = 64;
  localparam int CHUNK_BYTES_16 = 16;

  function automatic logic is_aligned16(input logic [3:0] lsb);
    return lsb == 4'h0;
  endfunction

endpackage

// File: rtl/prism_sp_acp_copy_seq_chunk_sel.sv
// Chunk size selection: 64-byte chunk only when enough bytes remain and both
// current addresses sit on a 64-byte boundary, otherwise 16 bytes.
module prism_sp_acp_chunk_sel
  import prism_sp_config::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic [LEN_WIDTH-1:0] i_remaining,
  input  logic [5:0]           i_ram_lsb,
  input  logic [5:0]           i_axi_lsb,
  output logic                 o_len64,
  output logic [LEN_WIDTH-1:0] o_incr
);

  always_comb begin
    o_len64 = (i_remaining >= LEN_WIDTH'(CHUNK_BYTES_64)) &&
              (i_ram_lsb == 6'd0) && (i_axi_lsb == 6'd0);
    o_incr  = o_len64 ? LEN_WIDTH'(CHUNK_BYTES_64) : LEN_WIDTH'(CHUNK_BYTES_16);
  end

endmodule

// File: rtl/prism_sp_acp_copy_seq.sv
// Block-copy sequencer: validates one copy request, then walks it as a series
// of 64/16-byte engine transactions, one start pulse per chunk.
module prism_sp_acp_copy_seq
  import prism_sp_config::*;
#(
  parameter int ACPRAM_ADDR_WIDTH = 20,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_dir,
  input  logic [ACPRAM_ADDR_WIDTH+3:0]  req_acpram_addr,
  input  logic [39:0]                   req_axi_addr,
  input  logic [LEN_WIDTH-1:0]          req_len,
  input  logic                          abort,
  output logic                          eng_read,
  output logic                          eng_write,
  output logic [ACPRAM_ADDR_WIDTH-1:0]  eng_acpram_addr,
  output logic [39:0]                   eng_axi_addr,
  output logic                          eng_len,
  input  logic                          eng_busy,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          aborted,
  output logic [LEN_WIDTH-5:0]          chunks_done
);

  localparam int RAW = ACPRAM_ADDR_WIDTH + 4;
  localparam int CW  = LEN_WIDTH - 4;

  state_t               r_state;
  state_t               w_next;
  logic                 r_dir;
  logic [RAW-1:0]       r_cur_ram;
  logic [39:0]          r_cur_axi;
  logic [LEN_WIDTH-1:0] r_rem;
  logic [CW-1:0]        r_chunks;
  logic                 r_err;
  logic                 r_aborted;
  logic                 r_abort_seen;

  logic                 w_len64;
  logic [LEN_WIDTH-1:0] w_incr;
  logic [LEN_WIDTH-1:0] w_rem_next;
  logic                 w_last;
  logic [RAW:0]         w_end;
  logic                 w_overflow;
  logic                 w_reject;
  logic                 w_stop;

  prism_sp_acp_chunk_sel #(
    .LEN_WIDTH (LEN_WIDTH)
  ) u_chunk_sel (
    .i_remaining (r_rem),
    .i_ram_lsb   (r_cur_ram[5:0]),
    .i_axi_lsb   (r_cur_axi[5:0]),
    .o_len64     (w_len64),
    .o_incr      (w_incr)
  );

  // End address is formed one bit wider so a request ending exactly at the
  // top of ACP RAM is legal and anything past it cannot wrap back in range.
  always_comb begin
    w_end      = {1'b0, r_cur_ram} + (RAW+1)'(r_rem);
    w_overflow = w_end > {1'b1, {RAW{1'b0}}};
    w_reject   = (r_rem == '0) || !is_aligned16(r_rem[3:0]) ||
                 !is_aligned16(r_cur_ram[3:0]) || !is_aligned16(r_cur_axi[3:0]) ||
                 w_overflow;
    w_rem_next = r_rem - w_incr;
    w_last     = (w_rem_next == '0);
    w_stop     = r_abort_seen || abort;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_next = ST_CHECK;
      ST_CHECK:  w_next = w_reject ? ST_FIN : ST_ISSUE;
      ST_ISSUE:  w_next = ST_SETTLE;
      ST_SETTLE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (!eng_busy) begin
          if (w_last || w_stop) w_next = ST_FIN;
          else                  w_next = ST_ISSUE;
        end
      end
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir        <= 1'b0;
      r_cur_ram    <= '0;
      r_cur_axi    <= '0;
      r_rem        <= '0;
      r_chunks     <= '0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_seen <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_dir     <= req_dir;
            r_cur_ram <= req_acpram_addr;
            r_cur_axi <= req_axi_addr;
            r_rem     <= req_len;
            r_chunks  <= '0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
          end
        end
        ST_CHECK: begin
          r_abort_seen <= 1'b0;
          if (w_reject) r_err <= 1'b1;
        end
        ST_ISSUE, ST_SETTLE: begin
          if (abort) r_abort_seen <= 1'b1;
        end
        ST_WAIT: begin
          if (abort) r_abort_seen <= 1'b1;
          // Chunk retires only once the engine drops busy; abort is honoured here.
          if (!eng_busy) begin
            r_cur_ram    <= r_cur_ram + RAW'(w_incr);
            r_cur_axi    <= r_cur_axi + 40'(w_incr);
            r_rem        <= w_rem_next;
            r_chunks     <= r_chunks + CW'(1);
            r_abort_seen <= 1'b0;
            if (!w_last && w_stop) r_aborted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready       = (r_state == ST_IDLE);
    busy            = (r_state != ST_IDLE);
    eng_read        = (r_state == ST_ISSUE) && !r_dir;
    eng_write       = (r_state == ST_ISSUE) && r_dir;
    eng_acpram_addr = r_cur_ram[RAW-1:4];
    eng_axi_addr    = r_cur_axi;
    eng_len         = w_len64;
    done            = (r_state == ST_FIN);
    err             = r_err;
    aborted         = r_aborted;
    chunks_done     = r_chunks;
  end

endmodule

// File: tb/tb_prism_sp_acp_copy_seq.sv
// Randomized and directed bench for the ACP block-copy sequencer with an
// engine busy model and a chunk-list reference model.
module tb_prism_sp_acp_copy_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_dir;
  logic [23:0] req_acpram_addr;
  logic [39:0] req_axi_addr;
  logic [15:0] req_len;
  logic        abort;
  logic        eng_read;
  logic        eng_write;
  logic [19:0] eng_acpram_addr;
  logic [39:0] eng_axi_addr;
  logic        eng_len;
  logic        eng_busy;
  logic        busy;
  logic        done;
  logic        err;
  logic        aborted;
  logic [11:0] chunks_done;

  int n_cmp = 0;
  int n_mis = 0;
  int lat   = 1;
  int bcnt  = 0;

  typedef struct packed {
    logic        dir;
    logic [19:0] ram;
    logic [39:0] axi;
    logic        len64;
  } chunk_t;

  chunk_t exp_q[$];
  chunk_t got_q[$];

  always #5 clk = ~clk;

  prism_sp_acp_copy_seq dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_dir         (req_dir),
    .req_acpram_addr (req_acpram_addr),
    .req_axi_addr    (req_axi_addr),
    .req_len         (req_len),
    .abort           (abort),
    .eng_read        (eng_read),
    .eng_write       (eng_write),
    .eng_acpram_addr (eng_acpram_addr),
    .eng_axi_addr    (eng_axi_addr),
    .eng_len         (eng_len),
    .eng_busy        (eng_busy),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .aborted         (aborted),
    .chunks_done     (chunks_done)
  );

  // Engine: busy rises the cycle after a start pulse and stays up lat cycles.
  always @(posedge clk) begin
    if (rst)                       bcnt <= 0;
    else if (eng_read | eng_write) bcnt <= lat;
    else if (bcnt > 0)             bcnt <= bcnt - 1;
  end
  assign eng_busy = (bcnt > 0);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_req(input logic d, input logic [23:0] ram, input logic [39:0] axi,
                         input logic [15:0] len, input int abort_at, input int latency);
    longint r, a;
    int     rem, sz, exp_n, n_pulse, first_k, done_k, abort_k;
    bit     rej, exp_ab, done_seen;
    logic   got_err, got_ab;
    logic [11:0] got_cd;
    chunk_t c;

    rej = (len == 0) || (len[3:0] != 0) || (ram[3:0] != 0) || (axi[3:0] != 0) ||
          (longint'(ram) + longint'(len) > 64'h100_0000);
    exp_q.delete();
    got_q.delete();
    r = longint'(ram);
    a = longint'(axi);
    rem = int'(len);
    if (!rej) begin
      while (rem > 0) begin
        sz = (rem >= 64 && (r % 64) == 0 && (a % 64) == 0) ? 64 : 16;
        c.dir   = d;
        c.ram   = 20'(r >> 4);
        c.axi   = 40'(a);
        c.len64 = (sz == 64);
        exp_q.push_back(c);
        r   += sz;
        a   += sz;
        rem -= sz;
      end
    end
    exp_n  = exp_q.size();
    exp_ab = 1'b0;
    if (abort_at > 0 && exp_n > abort_at) begin
      exp_n  = abort_at;
      exp_ab = 1'b1;
    end

    lat = latency;
    @(negedge clk);
    check_eq("ready_before_req", req_ready, 1);
    req_valid       = 1'b1;
    req_dir         = d;
    req_acpram_addr = ram;
    req_axi_addr    = axi;
    req_len         = len;
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    n_pulse = 0; first_k = 0; done_k = 0; abort_k = -1;
    done_seen = 1'b0; got_err = 1'b0; got_ab = 1'b0; got_cd = '0;
    for (int k = 1; k <= 3000 && !done_seen; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if (eng_read || eng_write) begin
        c.dir   = eng_write;
        c.ram   = eng_acpram_addr;
        c.axi   = eng_axi_addr;
        c.len64 = eng_len;
        got_q.push_back(c);
        n_pulse++;
        if (n_pulse == 1) first_k = k;
        if (eng_read && eng_write) check_eq("both_pulses", 1, 0);
        if (n_pulse == abort_at) abort_k = k + 2;
      end
      if (done) begin
        done_seen = 1'b1;
        done_k    = k;
        got_err   = err;
        got_ab    = aborted;
        got_cd    = chunks_done;
      end
      abort = (k == abort_k);
    end
    abort = 1'b0;

    check_eq("done_seen", done_seen, 1);
    check_eq("err", got_err, rej);
    check_eq("pulse_count", got_q.size(), exp_n);
    check_eq("chunks_done", got_cd, rej ? 0 : exp_n);
    if (rej) begin
      check_eq("reject_done_latency", done_k, 2);
    end else begin
      check_eq("first_pulse_latency", first_k, 2);
      check_eq("aborted", got_ab, exp_ab);
      for (int i = 0; i < exp_n && i < got_q.size(); i++)
        check_eq($sformatf("chunk%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    @(posedge clk);
    #1;
    check_eq("idle_after_done", req_ready, 1);
    check_eq("err_held", err, rej);
    check_eq("done_one_cycle", done, 0);
  endtask

  initial begin
    logic        d;
    logic [23:0] ram;
    logic [39:0] axi;
    logic [15:0] len;
    int          cnt;

    rst = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_acpram_addr = '0;
    req_axi_addr = '0; req_len = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", {eng_read, eng_write}, 0);
    check_eq("rst_done_err_ab", {done, err, aborted}, 0);
    check_eq("rst_chunks", chunks_done, 0);
    check_eq("rst_eng_addr", {eng_acpram_addr, eng_axi_addr, eng_len}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_req(1'b0, 24'h000000, 40'h1000, 16'd256, 0, 2);
    run_req(1'b0, 24'h000010, 40'h2010, 16'd96,  0, 1);
    run_req(1'b1, 24'h000000, 40'h3000, 16'd80,  0, 3);
    run_req(1'b0, 24'h000000, 40'h1000, 16'h18,  0, 1);
    run_req(1'b0, 24'h000000, 40'h1004, 16'd64,  0, 1);
    run_req(1'b0, 24'h000000, 40'h4000, 16'd0,   0, 1);
    run_req(1'b0, 24'h000008, 40'h4000, 16'd64,  0, 1);
    run_req(1'b0, 24'h000000, 40'h4000, 16'd512, 2, 4);
    run_req(1'b1, 24'hFFFFC0, 40'h5000, 16'd64,  0, 1);
    run_req(1'b1, 24'hFFFFC0, 40'h5000, 16'd80,  0, 1);
    run_req(1'b0, 24'h000040, 40'h6020, 16'd128, 0, 0);

    // Abort outside a request must have no effect on the next one.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    run_req(1'b1, 24'h000100, 40'h7000, 16'd192, 0, 2);

    for (int it = 0; it < 24; it++) begin
      d   = 1'($urandom_range(0, 1));
      ram = 24'($urandom_range(0, 4095)) << 4;
      if ($urandom_range(0, 7) == 0) ram = ram | 24'($urandom_range(1, 15));
      axi = 40'h1_0000_0000 + (40'($urandom_range(0, 4095)) << 4);
      len = 16'($urandom_range(1, 24) * 16);
      if ($urandom_range(0, 9) == 0) len = 16'd0;
      if ($urandom_range(0, 9) == 0) len = len | 16'h8;
      run_req(d, ram, axi, len,
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 4));
    end

    // Reset in the middle of a long engine transaction.
    lat = 20;
    @(negedge clk);
    req_valid = 1'b1; req_dir = 1'b0; req_acpram_addr = '0;
    req_axi_addr = 40'h8000; req_len = 16'd256;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("busy_before_rst", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_ready", req_ready, 1);
    check_eq("midrst_chunks", chunks_done, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (eng_read || eng_write) cnt++;
    end
    check_eq("pulses_after_rst", cnt, 0);
    check_eq("idle_after_rst", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
